// File: rtl/asrm_bus_bridge.sv
// CPU-to-memory-bus bridge: single-outstanding request FSM (IDLE/REQ/DONE)
// with a wait-cycle timeout, sticky error flag and saturating timeout counter.
module asrm_bus_bridge #(
    parameter int wordsize = 16,
    parameter int timeout  = 15
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_req,
    input  logic [wordsize-1:0] cpu_addr,
    input  logic [wordsize-1:0] cpu_wdata,
    input  logic                cpu_write_en,
    output logic [wordsize-1:0] cpu_rdata,
    output logic                cpu_stall,
    output logic                bus_req,
    output logic [wordsize-1:0] bus_addr,
    output logic [wordsize-1:0] bus_wdata,
    output logic                bus_we,
    input  logic                bus_ack,
    input  logic [wordsize-1:0] bus_rdata,
    input  logic                err_clr,
    output logic                bus_err,
    output logic [7:0]          timeout_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // The wait counter starts at 0 in the first REQ cycle, so reaching
    // timeout-1 without an ack means exactly `timeout` REQ cycles elapsed.
    localparam logic [7:0] WAIT_LAST = 8'(timeout - 1);

    state_t                state_q, state_d;
    logic [7:0]            wait_q, wait_d;
    logic                  bus_req_q, bus_req_d;
    logic [wordsize-1:0]   bus_addr_q, bus_addr_d;
    logic [wordsize-1:0]   bus_wdata_q, bus_wdata_d;
    logic                  bus_we_q, bus_we_d;
    logic [wordsize-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                  bus_err_q, bus_err_d;
    logic [7:0]            tmo_cnt_q, tmo_cnt_d;
    logic                  timeout_s;
    logic                  cpu_stall_s;

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wait_q      <= 8'd0;
            bus_req_q   <= 1'b0;
            bus_addr_q  <= {wordsize{1'b0}};
            bus_wdata_q <= {wordsize{1'b0}};
            bus_we_q    <= 1'b0;
            cpu_rdata_q <= {wordsize{1'b0}};
            bus_err_q   <= 1'b0;
            tmo_cnt_q   <= 8'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            bus_req_q   <= bus_req_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            cpu_rdata_q <= cpu_rdata_d;
            bus_err_q   <= bus_err_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    // Next-state and transaction datapath
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        bus_req_d   = bus_req_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        cpu_rdata_d = cpu_rdata_q;
        timeout_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    bus_addr_d  = cpu_addr;
                    bus_wdata_d = cpu_wdata;
                    bus_we_d    = cpu_write_en;
                    bus_req_d   = 1'b1;
                    wait_d      = 8'd0;
                    state_d     = ST_REQ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_REQ: begin
                // An ack in the final wait cycle beats the timeout.
                if (bus_ack) begin
                    if (!bus_we_q) begin
                        cpu_rdata_d = bus_rdata;
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else if (wait_q == WAIT_LAST) begin
                    timeout_s = 1'b1;
                    if (!bus_we_q) begin
                        cpu_rdata_d = {wordsize{1'b0}};
                    end else begin
                        cpu_rdata_d = cpu_rdata_q;
                    end
                    bus_req_d = 1'b0;
                    state_d   = ST_DONE;
                end else begin
                    wait_d    = wait_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // Error flag and saturating timeout counter; a timeout overrides err_clr
    always_comb begin
        bus_err_d = bus_err_q;
        tmo_cnt_d = tmo_cnt_q;
        if (timeout_s) begin
            bus_err_d = 1'b1;
            if (err_clr) begin
                tmo_cnt_d = 8'd1;
            end else if (tmo_cnt_q == 8'hFF) begin
                tmo_cnt_d = tmo_cnt_q;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
            end
        end else if (err_clr) begin
            bus_err_d = 1'b0;
            tmo_cnt_d = 8'd0;
        end else begin
            bus_err_d = bus_err_q;
        end
    end

    // CPU stall: follows cpu_req in IDLE (including during reset)
    always_comb begin
        cpu_stall_s = cpu_req;
        case (state_q)
            ST_IDLE: cpu_stall_s = cpu_req;
            ST_REQ:  cpu_stall_s = 1'b1;
            ST_DONE: cpu_stall_s = 1'b0;
            default: cpu_stall_s = cpu_req;
        endcase
    end

    assign cpu_stall     = cpu_stall_s;
    assign cpu_rdata     = cpu_rdata_q;
    assign bus_req       = bus_req_q;
    assign bus_addr      = bus_addr_q;
    assign bus_wdata     = bus_wdata_q;
    assign bus_we        = bus_we_q;
    assign bus_err       = bus_err_q;
    assign timeout_count = tmo_cnt_q;

endmodule

// File: tb/tb_asrm_bus_bridge.sv
// Self-checking bench for asrm_bus_bridge: directed scenarios plus random
// transactions scored against a transaction-level latency/error model.
module tb_asrm_bus_bridge;

    localparam int W  = 16;
    localparam int TO = 15;

    logic         clk = 1'b0;
    logic         reset;
    logic         cpu_req;
    logic [W-1:0] cpu_addr;
    logic [W-1:0] cpu_wdata;
    logic         cpu_write_en;
    logic [W-1:0] cpu_rdata;
    logic         cpu_stall;
    logic         bus_req;
    logic [W-1:0] bus_addr;
    logic [W-1:0] bus_wdata;
    logic         bus_we;
    logic         bus_ack;
    logic [W-1:0] bus_rdata;
    logic         err_clr;
    logic         bus_err;
    logic [7:0]   timeout_count;

    int           n_cmp  = 0;
    int           n_fail = 0;
    logic [W-1:0] rd_exp;
    logic         err_exp;
    int           tc_exp;

    asrm_bus_bridge #(.wordsize(W), .timeout(TO)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_write_en(cpu_write_en), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .bus_req(bus_req), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .err_clr(err_clr), .bus_err(bus_err), .timeout_count(timeout_count)
    );

    always #5 clk = ~clk;

    // One complete CPU transaction starting just after an edge in IDLE.
    // ack_n: REQ cycle (1-based) carrying bus_ack; outside 1..TO means no ack.
    // clr: pulse err_clr in REQ cycle TO (coincides with a timeout, if any).
    task automatic run_txn(input logic [W-1:0] addr, input logic [W-1:0] wdata,
                           input logic we, input logic [W-1:0] rdata,
                           input int ack_n, input logic clr);
        int   cyc;
        int   k;
        int   exp_lat;
        logic done;
        logic to;
        logic clr_hit;
        cpu_req = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_write_en = we;
        bus_ack = 1'b0; err_clr = 1'b0;
        #1;
        n_cmp++;
        if (cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL idle_stall: got %b want 1", cpu_stall);
        end
        cyc = 1; done = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1; cyc++;
            if (cpu_stall === 1'b0) begin
                done = 1'b1;
            end else begin
                k = cyc - 1;
                n_cmp++;
                if ({bus_req, bus_we, bus_addr, bus_wdata} !== {1'b1, we, addr, wdata}) begin
                    n_fail++;
                    $display("FAIL req_hold c%0d: got req=%b we=%b a=%h d=%h want 1 %b %h %h",
                             k, bus_req, bus_we, bus_addr, bus_wdata, we, addr, wdata);
                end
                cpu_addr = W'($urandom); cpu_wdata = W'($urandom);
                cpu_write_en = 1'($urandom);
                bus_ack   = (k == ack_n);
                bus_rdata = (k == ack_n) ? rdata : W'($urandom);
                err_clr   = clr && (k == TO);
            end
        end
        bus_ack = 1'b0; err_clr = 1'b0;
        to      = !(ack_n >= 1 && ack_n <= TO);
        clr_hit = clr && (to || ack_n == TO);
        exp_lat = to ? 2 + TO : 2 + ack_n;
        if (!we) rd_exp = to ? W'(0) : rdata;
        if (to) begin
            err_exp = 1'b1;
            tc_exp  = clr_hit ? 1 : ((tc_exp >= 255) ? 255 : tc_exp + 1);
        end else if (clr_hit) begin
            err_exp = 1'b0; tc_exp = 0;
        end
        n_cmp++;
        if (!done || cyc != exp_lat) begin
            n_fail++; $display("FAIL latency: got %0d (done=%b) want %0d", cyc, done, exp_lat);
        end
        n_cmp++;
        if ({bus_req, cpu_rdata, bus_err, timeout_count} !== {1'b0, rd_exp, err_exp, 8'(tc_exp)}) begin
            n_fail++;
            $display("FAIL done_state: got req=%b rd=%h err=%b tc=%0d want 0 %h %b %0d",
                     bus_req, cpu_rdata, bus_err, timeout_count, rd_exp, err_exp, tc_exp);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({cpu_stall, bus_req} !== 2'b00) begin
            n_fail++; $display("FAIL idle_after: got stall=%b req=%b want 0 0", cpu_stall, bus_req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cpu_req = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_write_en = 1'b0;
        bus_ack = 1'b0; bus_rdata = '0; err_clr = 1'b0;
        rd_exp = '0; err_exp = 1'b0; tc_exp = 0;
        #2;
        n_cmp++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, bus_err, timeout_count, cpu_stall} !== '0) begin
            n_fail++;
            $display("FAIL reset_vals: got req=%b we=%b a=%h d=%h rd=%h err=%b tc=%0d stall=%b want all 0",
                     bus_req, bus_we, bus_addr, bus_wdata, cpu_rdata, bus_err, timeout_count, cpu_stall);
        end
        cpu_req = 1'b1; #1;
        n_cmp++;
        if (cpu_stall !== 1'b1) begin
            n_fail++; $display("FAIL reset_stall: got %b want 1", cpu_stall);
        end
        cpu_req = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_read_fast();
        run_txn(16'h0010, 16'h0000, 1'b0, 16'hBEEF, 1, 1'b0);
    endtask

    task automatic test_write_wait();
        run_txn(16'h0020, 16'h1234, 1'b1, 16'hDEAD, 4, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(16'h0030, 16'h0000, 1'b0, 16'h5555, 0, 1'b0);
    endtask

    task automatic test_ack_race();
        logic [W-1:0] rd_before;
        run_txn(16'h0040, 16'h0000, 1'b0, 16'hC0DE, TO, 1'b0);
        rd_before = rd_exp;
        bus_ack = 1'b1; bus_rdata = 16'h7777;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_req, cpu_stall, cpu_rdata, bus_err} !== {1'b0, 1'b0, rd_before, err_exp}) begin
            n_fail++;
            $display("FAIL idle_ack: got req=%b stall=%b rd=%h err=%b want 0 0 %h %b",
                     bus_req, cpu_stall, cpu_rdata, bus_err, rd_before, err_exp);
        end
        bus_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        cpu_req = 1'b1; cpu_addr = 16'h0055; cpu_write_en = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if (bus_req !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset_req: got %b want 1", bus_req);
        end
        #2 reset = 1'b1;
        #1;
        rd_exp = '0; err_exp = 1'b0; tc_exp = 0;
        n_cmp++;
        if ({bus_req, bus_err, cpu_stall} !== 3'b001) begin
            n_fail++;
            $display("FAIL async_reset: got req=%b err=%b stall=%b want 0 0 1", bus_req, bus_err, cpu_stall);
        end
        @(negedge clk); #1 reset = 1'b0;
        @(posedge clk); #1;
        n_cmp++;
        if ({bus_req, cpu_stall, bus_addr} !== {1'b1, 1'b1, 16'h0055}) begin
            n_fail++;
            $display("FAIL post_reset_req: got req=%b stall=%b a=%h want 1 1 0055", bus_req, cpu_stall, bus_addr);
        end
        bus_ack = 1'b1; bus_rdata = 16'hA5A5;
        @(posedge clk); #1;
        bus_ack = 1'b0;
        rd_exp = 16'hA5A5;
        n_cmp++;
        if ({cpu_stall, cpu_rdata} !== {1'b0, rd_exp}) begin
            n_fail++;
            $display("FAIL post_reset_done: got stall=%b rd=%h want 0 %h", cpu_stall, cpu_rdata, rd_exp);
        end
        cpu_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_err_clr_saturation();
        while (tc_exp < 255) run_txn(W'($urandom), W'($urandom), 1'b0, W'($urandom), 0, 1'b0);
        run_txn(W'($urandom), W'($urandom), 1'b1, W'($urandom), 0, 1'b0);
        run_txn(W'($urandom), W'($urandom), 1'b0, W'($urandom), 0, 1'b1);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0; err_exp = 1'b0; tc_exp = 0;
        n_cmp++;
        if ({bus_err, timeout_count} !== {1'b0, 8'd0}) begin
            n_fail++; $display("FAIL err_clr_alone: got err=%b tc=%0d want 0 0", bus_err, timeout_count);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            run_txn(W'($urandom), W'($urandom), 1'($urandom), W'($urandom),
                    int'($urandom_range(1, TO + 3)), ($urandom_range(0, 3) == 0));
        end
    endtask

    initial begin
        test_reset();
        test_read_fast();
        test_write_wait();
        test_timeout();
        test_ack_race();
        test_async_reset();
        test_err_clr_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
